// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor.
// One shared 1-bit full-adder cell is stepped over WIDTH cycles, LSB first,
// under a start/busy/done handshake. Subtraction is A + ~B + 1.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             bitX;
  logic             bitY;
  logic             bitSum;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             lastBit;

  // The single full-adder cell working on operand bit cnt_q, plus the shifted partial sum.
  always_comb begin
    bitX    = opA_q[cnt_q];
    bitY    = opB_q[cnt_q];
    bitSum  = bitX ^ bitY ^ carry_q;
    carry_d = (bitX & bitY) | (bitX & carry_q) | (bitY & carry_q);
    sum_d   = {bitSum, sum_q[WIDTH-1:1]};
    lastBit = (cnt_q == LastCnt);
  end

  // Controller FSM: accepts a request in idle, walks the bits, then pulses done for one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            opA_q   <= a_i;
            opB_q   <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : cin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (lastBit) begin
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of the bit-serial adder at WIDTH=8,
// plus an exhaustive sweep of a WIDTH=2 instance against a reference model.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rstN;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   logic       nStart;
   logic [1:0] nA;
   logic [1:0] nB;
   logic       nCin;
   logic       nSub;
   logic       nBusy;
   logic       nDone;
   logic [1:0] nSum;
   logic       nCout;
   logic       nOvf;

   int checks;
   int errors;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk_i(clk), .rst_n_i(rstN), .start_i(start), .a_i(a), .b_i(b),
      .cin_i(cin), .sub_i(sub), .busy_o(busy), .done_o(done),
      .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
   );

   serial_add_ctrl #(.WIDTH(2)) dutNarrow (
      .clk_i(clk), .rst_n_i(rstN), .start_i(nStart), .a_i(nA), .b_i(nB),
      .cin_i(nCin), .sub_i(nSub), .busy_o(nBusy), .done_o(nDone),
      .sum_o(nSum), .cout_o(nCout), .ovf_o(nOvf)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present a request to the 8-bit instance for one edge, then scramble the inputs.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                input logic c, input logic s);
      a = av; b = bv; cin = c; sub = s; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~av; b = ~bv; cin = ~c; sub = ~s;
   endtask

   // Wait (bounded) for done; reports cycles waited and how many of them had busy high.
   task automatic waitDone(input bit narrow, output int cycles, output int busyCycles);
      cycles = 0;
      busyCycles = 0;
      while (((narrow ? nDone : done) !== 1'b1) && cycles < 20) begin
         if ((narrow ? nBusy : busy) === 1'b1) busyCycles++;
         tick();
         cycles++;
      end
   endtask

   // Full 8-bit transaction with latency, handshake and hold checks.
   task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, input logic s, input logic [7:0] expSum,
                        input logic expCout, input logic expOvf, input logic [7:0] prevSum);
      int cyc;
      int bcyc;
      applyStimulus(av, bv, c, s);
      checkOutput({tag, ".busyAfterAccept"}, busy, 1);
      checkOutput({tag, ".sumHeldOnAccept"}, sum, prevSum);
      waitDone(1'b0, cyc, bcyc);
      checkOutput({tag, ".latency"}, cyc, 8);
      checkOutput({tag, ".busyCycles"}, bcyc, 8);
      checkOutput({tag, ".busyAtDone"}, busy, 0);
      checkOutput({tag, ".sum"}, sum, expSum);
      checkOutput({tag, ".cout"}, cout, expCout);
      checkOutput({tag, ".ovf"}, ovf, expOvf);
      tick();
      checkOutput({tag, ".donePulseEnds"}, done, 0);
      tick();
      checkOutput({tag, ".sumHeldIdle"}, sum, expSum);
   endtask

   // Reference: {ovf, cout, sum} from plain wide addition and sign comparison.
   function automatic logic [65:0] refModel(input int w, input logic [63:0] av,
                                            input logic [63:0] bv, input logic c,
                                            input logic s);
      logic [63:0] mask;
      logic [63:0] bb;
      logic [64:0] full;
      logic [63:0] res;
      logic        co;
      logic        ov;
      mask = (64'd1 << w) - 64'd1;
      bb   = (s ? ~bv : bv) & mask;
      full = {1'b0, av & mask} + {1'b0, bb} + {64'd0, (s ? 1'b1 : c)};
      res  = full[63:0] & mask;
      co   = full[w];
      ov   = (av[w-1] == bb[w-1]) && (res[w-1] != av[w-1]);
      return {ov, co, res};
   endfunction

   // Directed sequence followed by the narrow exhaustive sweep.
   initial begin
      int cyc;
      int bcyc;
      int doneSeen;
      logic [65:0] exp;
      checks = 0;
      errors = 0;
      rstN = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      nStart = 1'b0; nA = '0; nB = '0; nCin = 1'b0; nSub = 1'b0;

      $display("[TB] reset from power-up");
      tick(); tick();
      checkOutput("rst0.busy", busy, 0);
      checkOutput("rst0.done", done, 0);
      checkOutput("rst0.sum", sum, 0);
      checkOutput("rst0.narrowBusy", nBusy, 0);

      $display("[TB] reset from mid-operation");
      rstN = 1'b1;
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
      tick(); tick(); tick();
      rstN = 1'b0;
      tick(); tick();
      checkOutput("rst1.busy", busy, 0);
      checkOutput("rst1.done", done, 0);
      checkOutput("rst1.sum", sum, 0);
      checkOutput("rst1.cout", cout, 0);
      checkOutput("rst1.ovf", ovf, 0);
      rstN = 1'b1;
      tick();

      $display("[TB] directed add / wrap / subtract");
      runOp("add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 8'h00);
      runOp("wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h8D);
      runOp("sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 8'h01);

      $display("[TB] start while busy");
      applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
      tick(); tick(); tick();
      start = 1'b1; a = 8'hAA; b = 8'h55;
      tick();
      start = 1'b0;
      waitDone(1'b0, cyc, bcyc);
      checkOutput("busyStart.latency", cyc, 4);
      checkOutput("busyStart.sum", sum, 8'h02);
      tick();
      checkOutput("busyStart.noSecondDone", done, 0);
      checkOutput("busyStart.idleBusy", busy, 0);
      applyStimulus(8'h03, 8'h04, 1'b0, 1'b0);
      checkOutput("afterDone.accepted", busy, 1);
      waitDone(1'b0, cyc, bcyc);
      checkOutput("afterDone.latency", cyc, 8);
      checkOutput("afterDone.sum", sum, 8'h07);
      tick();

      $display("[TB] abort by reset at bit 4");
      applyStimulus(8'hC3, 8'h3C, 1'b0, 1'b0);
      tick(); tick(); tick(); tick();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.done", done, 0);
      checkOutput("abort.sum", sum, 0);
      checkOutput("abort.cout", cout, 0);
      checkOutput("abort.ovf", ovf, 0);
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) doneSeen++;
      end
      checkOutput("abort.noDoneAfter", doneSeen, 0);

      $display("[TB] WIDTH=2 exhaustive sweep");
      for (int av = 0; av < 4; av++) begin
         for (int bv = 0; bv < 4; bv++) begin
            for (int c = 0; c < 2; c++) begin
               for (int s = 0; s < 2; s++) begin
                  nA = 2'(av); nB = 2'(bv); nCin = c[0]; nSub = s[0]; nStart = 1'b1;
                  tick();
                  nStart = 1'b0;
                  nA = ~nA; nB = ~nB;
                  waitDone(1'b1, cyc, bcyc);
                  exp = refModel(2, 64'(av), 64'(bv), c[0], s[0]);
                  checkOutput($sformatf("w2.a%0d.b%0d.c%0d.s%0d.latency", av, bv, c, s), cyc, 2);
                  checkOutput($sformatf("w2.a%0d.b%0d.c%0d.s%0d.sum", av, bv, c, s), nSum, exp[63:0]);
                  checkOutput($sformatf("w2.a%0d.b%0d.c%0d.s%0d.cout", av, bv, c, s), nCout, exp[64]);
                  checkOutput($sformatf("w2.a%0d.b%0d.c%0d.s%0d.ovf", av, bv, c, s), nOvf, exp[65]);
                  tick();
               end
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
